// File: rtl/loteria_input_conditioner.sv
// -----------------------------------------------------------------------------
// loteria_input_conditioner
// Front end for the lottery FSM. Raw pushbuttons and digit switches are
// synchronised and debounced. Each accepted press produces exactly one
// clock-wide pulse. Digits above 9 are rejected and reported on num_err.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// loteria_key_debounce
// Press/release qualifier for one key. Its input is the synchronised key
// level, already normalised so that 1 means pressed. o_qualify is high in the
// cycle whose rising edge moves the FSM from PRESS_DB to HELD. The parent
// registers the actual pulse on that edge, so the pulse lasts exactly one
// cycle.
// -----------------------------------------------------------------------------
module loteria_key_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_pressed,
   output logic o_qualify
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PRESS_DB = 2'd1,
      ST_HELD     = 2'd2,
      ST_REL_DB   = 2'd3
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             w_cnt_done;

   assign w_cnt_done = (r_cnt == CNT_LAST);

   // The press is accepted on the last stable cycle of PRESS_DB.
   assign o_qualify = (r_state == ST_PRESS_DB) && i_pressed && w_cnt_done;

   // Debounce FSM. Reset lands in REL_DB so that a key already held at reset
   // release settles into HELD and does not fire.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_REL_DB;
         r_cnt   <= CNT_ZERO;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_pressed) begin
                  r_state <= ST_PRESS_DB;
                  r_cnt   <= CNT_ZERO;
               end else begin
                  r_state <= ST_IDLE;
                  r_cnt   <= CNT_ZERO;
               end
            end
            ST_PRESS_DB: begin
               if (!i_pressed) begin
                  // Bounce: restart qualification from IDLE.
                  r_state <= ST_IDLE;
                  r_cnt   <= CNT_ZERO;
               end else if (w_cnt_done) begin
                  r_state <= ST_HELD;
                  r_cnt   <= CNT_ZERO;
               end else begin
                  r_state <= ST_PRESS_DB;
                  r_cnt   <= r_cnt + CNT_ONE;
               end
            end
            ST_HELD: begin
               if (!i_pressed) begin
                  r_state <= ST_REL_DB;
                  r_cnt   <= CNT_ZERO;
               end else begin
                  r_state <= ST_HELD;
                  r_cnt   <= CNT_ZERO;
               end
            end
            ST_REL_DB: begin
               if (i_pressed) begin
                  // Release bounce: back to HELD without a new pulse.
                  r_state <= ST_HELD;
                  r_cnt   <= CNT_ZERO;
               end else if (w_cnt_done) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= CNT_ZERO;
               end else begin
                  r_state <= ST_REL_DB;
                  r_cnt   <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_state <= ST_REL_DB;
               r_cnt   <= CNT_ZERO;
            end
         endcase
      end
   end

endmodule

// -----------------------------------------------------------------------------
// Top level: synchronisers, two debouncers, digit validation and output
// pulse registers.
// -----------------------------------------------------------------------------
module loteria_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_insert,
   input  logic       key_finish,
   input  logic [3:0] sw_num,
   output logic       insert,
   output logic       finish,
   output logic [3:0] num,
   output logic       num_err
);

   // Raw level a key shows while it is pressed.
   localparam logic KEY_PRESSED_LVL = KEY_ACTIVE_LOW ? 1'b0 : 1'b1;
   localparam logic [3:0] DIGIT_MAX = 4'd9;

   logic       r_ins_meta;
   logic       r_ins_sync;
   logic       r_fin_meta;
   logic       r_fin_sync;
   logic [3:0] r_sw_meta;
   logic [3:0] r_sw_sync;

   logic       w_ins_pressed;
   logic       w_fin_pressed;
   logic       w_ins_qualify;
   logic       w_fin_qualify;
   logic       w_digit_ok;

   logic       r_insert;
   logic       r_finish;
   logic       r_num_err;
   logic [3:0] r_num;

   // Two-flop synchronisers. The key flops reset to the pressed level, so a
   // key held through reset is never taken for a fresh press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ins_meta <= KEY_PRESSED_LVL;
         r_ins_sync <= KEY_PRESSED_LVL;
         r_fin_meta <= KEY_PRESSED_LVL;
         r_fin_sync <= KEY_PRESSED_LVL;
         r_sw_meta  <= 4'd0;
         r_sw_sync  <= 4'd0;
      end else begin
         r_ins_meta <= key_insert;
         r_ins_sync <= r_ins_meta;
         r_fin_meta <= key_finish;
         r_fin_sync <= r_fin_meta;
         r_sw_meta  <= sw_num;
         r_sw_sync  <= r_sw_meta;
      end
   end

   // Normalise both keys so that 1 means pressed.
   assign w_ins_pressed = (r_ins_sync == KEY_PRESSED_LVL);
   assign w_fin_pressed = (r_fin_sync == KEY_PRESSED_LVL);

   loteria_key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_insert_db (
      .clk       (clk),
      .reset     (reset),
      .i_pressed (w_ins_pressed),
      .o_qualify (w_ins_qualify)
   );

   loteria_key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_finish_db (
      .clk       (clk),
      .reset     (reset),
      .i_pressed (w_fin_pressed),
      .o_qualify (w_fin_qualify)
   );

   assign w_digit_ok = (r_sw_sync <= DIGIT_MAX);

   // Output pulses and digit capture. The digit is taken only on an accepted
   // insert, so switch motion at any other time is ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_insert  <= 1'b0;
         r_finish  <= 1'b0;
         r_num_err <= 1'b0;
         r_num     <= 4'd0;
      end else begin
         r_insert  <= w_ins_qualify & w_digit_ok;
         r_num_err <= w_ins_qualify & ~w_digit_ok;
         r_finish  <= w_fin_qualify;
         if (w_ins_qualify && w_digit_ok) begin
            r_num <= r_sw_sync;
         end else begin
            r_num <= r_num;
         end
      end
   end

   assign insert  = r_insert;
   assign finish  = r_finish;
   assign num_err = r_num_err;
   assign num     = r_num;

endmodule

// File: tb/tb_loteria_input_conditioner.sv
// -----------------------------------------------------------------------------
// Self-checking bench for loteria_input_conditioner (DEBOUNCE_CYCLES=4,
// active-low keys). A reference model works from sampled key history. A press
// fires once the synchronised key has read pressed for N+1 consecutive edges,
// and only while armed. The key re-arms after N+1 consecutive released edges.
// -----------------------------------------------------------------------------
module tb_loteria_input_conditioner;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       key_insert;
   logic       key_finish;
   logic [3:0] sw_num;
   logic       insert;
   logic       finish;
   logic [3:0] num;
   logic       num_err;

   always #5 clk = ~clk;

   loteria_input_conditioner #(
      .DEBOUNCE_CYCLES (N),
      .KEY_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key_insert (key_insert),
      .key_finish (key_finish),
      .sw_num     (sw_num),
      .insert     (insert),
      .finish     (finish),
      .num        (num),
      .num_err    (num_err)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state.
   bit         m_hi1, m_hi2, m_hf1, m_hf2;
   logic [3:0] m_sw1, m_sw2;
   int         m_iprun, m_irrun, m_fprun, m_frrun;
   bit         m_iarm, m_farm;
   logic       exp_ins, exp_fin, exp_err;
   logic [3:0] exp_num;

   // Per-test statistics.
   int step;
   int n_ins, n_fin, n_err;
   int ins_at, fin_at, err_at;

   typedef struct {
      logic       ki;
      logic       kf;
      logic [3:0] sw;
      logic       e_ins;
      logic       e_fin;
      logic       e_err;
      logic [3:0] e_num;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_hi1 = 1'b1; m_hi2 = 1'b1; m_hf1 = 1'b1; m_hf2 = 1'b1;
      m_sw1 = 4'd0; m_sw2 = 4'd0;
      m_iprun = 0; m_irrun = 0; m_fprun = 0; m_frrun = 0;
      m_iarm = 1'b0; m_farm = 1'b0;
      exp_ins = 1'b0; exp_fin = 1'b0; exp_err = 1'b0; exp_num = 4'd0;
   endtask

   task automatic key_model(input bit p, inout int prun, inout int rrun,
                            inout bit armed, output bit fire);
      fire = 1'b0;
      if (p) begin
         prun++;
         rrun = 0;
      end else begin
         rrun++;
         prun = 0;
      end
      if (!armed && rrun >= N + 1) armed = 1'b1;
      if (armed && prun == N + 1) begin
         fire  = 1'b1;
         armed = 1'b0;
      end
   endtask

   task automatic model_step();
      bit         fi, ff;
      logic [3:0] s;
      if (reset) begin
         model_reset();
      end else begin
         s = m_sw2;
         key_model(m_hi2, m_iprun, m_irrun, m_iarm, fi);
         key_model(m_hf2, m_fprun, m_frrun, m_farm, ff);
         m_hi2 = m_hi1; m_hi1 = (key_insert == 1'b0);
         m_hf2 = m_hf1; m_hf1 = (key_finish == 1'b0);
         m_sw2 = m_sw1; m_sw1 = sw_num;
         exp_ins = fi && (s <= 4'd9);
         exp_err = fi && (s > 4'd9);
         exp_fin = ff;
         if (exp_ins) exp_num = s;
      end
   endtask

   task automatic clear_stats();
      step = 0; n_ins = 0; n_fin = 0; n_err = 0;
      ins_at = -1; fin_at = -1; err_at = -1;
   endtask

   // One clock: model advances on the edge, the DUT is compared on the
   // following falling edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("model", {25'd0, insert, finish, num_err, num},
                     {25'd0, exp_ins, exp_fin, exp_err, exp_num});
      if (insert)  begin n_ins++; ins_at = step; end
      if (finish)  begin n_fin++; fin_at = step; end
      if (num_err) begin n_err++; err_at = step; end
      step++;
   endtask

   task automatic run(input logic ki, input logic kf, input logic [3:0] sw, input int n);
      key_insert = ki; key_finish = kf; sw_num = sw;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      int hold_i, hold_f;

      // Row k is driven before edge Ek; its expectation holds after Ek.
      for (int k = 0; k < 10; k++) begin
         tbl[k].ki    = 1'b0;
         tbl[k].kf    = 1'b1;
         tbl[k].sw    = 4'd5;
         tbl[k].e_ins = (k == 6);
         tbl[k].e_fin = 1'b0;
         tbl[k].e_err = 1'b0;
         tbl[k].e_num = (k >= 6) ? 4'd5 : 4'd0;
      end

      // Reset with both keys released.
      reset = 1'b1; key_insert = 1'b1; key_finish = 1'b1; sw_num = 4'd3;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_state", {25'd0, insert, finish, num_err, num}, 32'd0);
      reset = 1'b0;
      clear_stats();
      run(1'b1, 1'b1, 4'd3, 20);
      check("idle_pulses", n_ins + n_fin + n_err, 32'd0);
      check("idle_num", {28'd0, num}, 32'd0);

      // Timing of a clean insert press, driven from the table.
      clear_stats();
      for (int k = 0; k < 10; k++) begin
         key_insert = tbl[k].ki; key_finish = tbl[k].kf; sw_num = tbl[k].sw;
         cycle();
         check($sformatf("tbl_E%0d", k), {25'd0, insert, finish, num_err, num},
               {25'd0, tbl[k].e_ins, tbl[k].e_fin, tbl[k].e_err, tbl[k].e_num});
      end
      run(1'b0, 1'b1, 4'd5, 20);
      check("hold30_one_pulse", n_ins, 32'd1);
      run(1'b1, 1'b1, 4'd5, 10);
      run(1'b0, 1'b1, 4'd5, 12);
      check("repress_pulse", n_ins, 32'd2);
      check("repress_num", {28'd0, num}, 32'd5);
      run(1'b1, 1'b1, 4'd5, 10);

      // Press bounce 0,0,1,0 then held, followed by a release glitch.
      clear_stats();
      run(1'b0, 1'b1, 4'd5, 2);
      run(1'b1, 1'b1, 4'd5, 1);
      run(1'b0, 1'b1, 4'd5, 12);
      check("bounce_count", n_ins, 32'd1);
      check("bounce_edge", ins_at, 32'd9);
      run(1'b1, 1'b1, 4'd5, 1);
      run(1'b0, 1'b1, 4'd5, 12);
      check("glitch_no_pulse", n_ins, 32'd1);
      run(1'b1, 1'b1, 4'd5, 10);

      // Out-of-range digit.
      clear_stats();
      run(1'b0, 1'b1, 4'd12, 10);
      check("err_count", n_err, 32'd1);
      check("err_edge", err_at, 32'd6);
      check("err_no_insert", n_ins, 32'd0);
      check("err_num_kept", {28'd0, num}, 32'd5);
      run(1'b1, 1'b1, 4'd12, 10);

      // Finish held across reset release.
      key_finish = 1'b0;
      reset = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      clear_stats();
      run(1'b1, 1'b0, 4'd12, 20);
      check("fin_held_no_pulse", n_fin, 32'd0);
      run(1'b1, 1'b1, 4'd12, 8);
      run(1'b1, 1'b0, 4'd12, 10);
      check("fin_after_release", n_fin, 32'd1);
      run(1'b1, 1'b1, 4'd12, 10);

      // Both keys pressed on the same edge.
      clear_stats();
      run(1'b0, 1'b0, 4'd7, 10);
      check("both_ins", n_ins, 32'd1);
      check("both_fin", n_fin, 32'd1);
      check("both_same_edge", fin_at, ins_at);
      check("both_edge", ins_at, 32'd6);
      check("both_num", {28'd0, num}, 32'd7);
      run(1'b1, 1'b1, 4'd7, 10);

      // Reset two cycles into PRESS_DB.
      clear_stats();
      run(1'b0, 1'b1, 4'd7, 5);
      #1 reset = 1'b1;
      model_reset();
      #1 check("async_reset", {25'd0, insert, finish, num_err, num}, 32'd0);
      cycle();
      reset = 1'b0;
      run(1'b0, 1'b1, 4'd7, 20);
      check("reset_no_pulse", n_ins, 32'd0);
      run(1'b1, 1'b1, 4'd7, 10);

      // Randomised bursts against the reference model.
      hold_i = 0; hold_f = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold_i == 0) begin
            key_insert = 1'($urandom_range(0, 1));
            hold_i = $urandom_range(1, 9);
         end
         if (hold_f == 0) begin
            key_finish = 1'($urandom_range(0, 1));
            hold_f = $urandom_range(1, 9);
         end
         if ($urandom_range(0, 3) == 0) sw_num = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 299) == 0) begin
            reset = 1'b1;
            model_reset();
         end
         cycle();
         reset = 1'b0;
         hold_i--; hold_f--;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
